// File: rtl/tl_arb_2to1.sv
// tl_arb_2to1: round-robin 2:1 TileLink-style arbiter with in-order response steering.
module tl_arb_2to1 #(
    parameter int A_W   = 53,
    parameter int D_W   = 43,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m0_a_valid,
    input  logic                     m1_a_valid,
    output logic                     m0_a_ready,
    output logic                     m1_a_ready,
    input  logic [A_W-1:0]           m0_a_channel,
    input  logic [A_W-1:0]           m1_a_channel,
    output logic                     m0_d_valid,
    output logic                     m1_d_valid,
    input  logic                     m0_d_ready,
    input  logic                     m1_d_ready,
    output logic [D_W-1:0]           m0_d_channel,
    output logic [D_W-1:0]           m1_d_channel,
    output logic                     m0_d_error,
    output logic                     m1_d_error,
    output logic                     s_a_valid,
    input  logic                     s_a_ready,
    output logic [A_W-1:0]           s_a_channel,
    input  logic                     s_d_valid,
    output logic                     s_d_ready,
    input  logic [D_W-1:0]           s_d_channel,
    input  logic                     s_d_error,
    input  logic                     backpressureslave,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     unexpected_d
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nx;
    logic ptr, grant, pick, sel, sel_v, full, allow, hs, empty, head, pop;
    logic [PW-1:0] wp, rp;
    logic [DEPTH-1:0] ids;
    always_comb begin
        pick = (m0_a_valid & m1_a_valid) ? ptr : m1_a_valid;
        sel = (state == LOCKED) ? grant : pick;
        sel_v = sel ? m1_a_valid : m0_a_valid;
        full = outstanding == CW'(DEPTH);
        allow = rst_n & ~full & ~backpressureslave;
        s_a_valid = sel_v & allow;
        s_a_channel = sel ? m1_a_channel : m0_a_channel;
        m0_a_ready = ~sel & s_a_ready & allow;
        m1_a_ready = sel & s_a_ready & allow;
        hs = s_a_valid & s_a_ready;
        state_nx = hs ? IDLE : (sel_v ? LOCKED : state);
        empty = outstanding == '0;
        head = ids[rp];
        // An empty FIFO still accepts D beats so a stray response cannot wedge the slave.
        s_d_ready = rst_n & (empty | (head ? m1_d_ready : m0_d_ready));
        m0_d_valid = s_d_valid & ~empty & ~head;
        m1_d_valid = s_d_valid & ~empty & head;
        m0_d_channel = m0_d_valid ? s_d_channel : '0;
        m1_d_channel = m1_d_valid ? s_d_channel : '0;
        m0_d_error = m0_d_valid & s_d_error;
        m1_d_error = m1_d_valid & s_d_error;
        pop = s_d_valid & s_d_ready & ~empty;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 1'b0;
            ptr <= 1'b0;
            wp <= '0;
            rp <= '0;
            outstanding <= '0;
            unexpected_d <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) grant <= pick;
            if (hs) ptr <= ~sel;
            if (hs) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            outstanding <= outstanding + CW'(hs) - CW'(pop);
            if (s_d_valid & empty) unexpected_d <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (hs) ids[wp] <= sel;
    end
endmodule

// File: tb/tb_tl_arb_2to1.sv
// tb_tl_arb_2to1: directed and random stimulus against a queue-based arbiter model.
module tb_tl_arb_2to1;
    localparam int A_W = 53;
    localparam int D_W = 43;
    localparam int DEPTH = 4;
    logic clk = 0, rst_n = 0;
    logic m0_a_valid = 0, m1_a_valid = 0, m0_a_ready, m1_a_ready;
    logic [A_W-1:0] m0_a_channel = '0, m1_a_channel = '0, s_a_channel;
    logic m0_d_valid, m1_d_valid, m0_d_ready = 0, m1_d_ready = 0;
    logic [D_W-1:0] m0_d_channel, m1_d_channel, s_d_channel = '0;
    logic m0_d_error, m1_d_error, s_a_valid, s_a_ready = 0;
    logic s_d_valid = 0, s_d_ready, s_d_error = 0, backpressureslave = 0;
    logic [$clog2(DEPTH):0] outstanding;
    logic unexpected_d;

    tl_arb_2to1 #(.A_W(A_W), .D_W(D_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_a_valid(m0_a_valid), .m1_a_valid(m1_a_valid),
        .m0_a_ready(m0_a_ready), .m1_a_ready(m1_a_ready),
        .m0_a_channel(m0_a_channel), .m1_a_channel(m1_a_channel),
        .m0_d_valid(m0_d_valid), .m1_d_valid(m1_d_valid),
        .m0_d_ready(m0_d_ready), .m1_d_ready(m1_d_ready),
        .m0_d_channel(m0_d_channel), .m1_d_channel(m1_d_channel),
        .m0_d_error(m0_d_error), .m1_d_error(m1_d_error),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_channel(s_a_channel),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_channel(s_d_channel),
        .s_d_error(s_d_error), .backpressureslave(backpressureslave),
        .outstanding(outstanding), .unexpected_d(unexpected_d)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int held = -1, last = 1, g;
    int q[$];
    bit unexp = 0, exp_sav, exp_sdr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit full;
        int h;
        g = held >= 0 ? held : ((m0_a_valid && m1_a_valid) ? 1 - last : (m1_a_valid ? 1 : 0));
        full = q.size() == DEPTH;
        exp_sav = (g == 1 ? m1_a_valid : m0_a_valid) && !full && !backpressureslave;
        chk("s_a_valid", 64'(s_a_valid), 64'(exp_sav));
        chk("s_a_channel", 64'(s_a_channel), 64'(g == 1 ? m1_a_channel : m0_a_channel));
        chk("m0_a_ready", 64'(m0_a_ready), 64'(g == 0 && s_a_ready && !full && !backpressureslave));
        chk("m1_a_ready", 64'(m1_a_ready), 64'(g == 1 && s_a_ready && !full && !backpressureslave));
        h = q.size() == 0 ? -1 : q[0];
        exp_sdr = h < 0 ? 1'b1 : (h == 1 ? m1_d_ready : m0_d_ready);
        chk("s_d_ready", 64'(s_d_ready), 64'(exp_sdr));
        chk("m0_d_valid", 64'(m0_d_valid), 64'(h == 0 && s_d_valid));
        chk("m1_d_valid", 64'(m1_d_valid), 64'(h == 1 && s_d_valid));
        chk("m0_d_channel", 64'(m0_d_channel), (h == 0 && s_d_valid) ? 64'(s_d_channel) : 64'd0);
        chk("m1_d_channel", 64'(m1_d_channel), (h == 1 && s_d_valid) ? 64'(s_d_channel) : 64'd0);
        chk("m0_d_error", 64'(m0_d_error), 64'(h == 0 && s_d_valid && s_d_error));
        chk("m1_d_error", 64'(m1_d_error), 64'(h == 1 && s_d_valid && s_d_error));
        chk("outstanding", 64'(outstanding), 64'(q.size()));
        chk("unexpected_d", 64'(unexpected_d), 64'(unexp));
    endtask

    task automatic step(input logic v0, v1, sar, bp, sdv, dr0, dr1);
        bit pop;
        m0_a_valid = v0; m1_a_valid = v1; s_a_ready = sar; backpressureslave = bp;
        s_d_valid = sdv; m0_d_ready = dr0; m1_d_ready = dr1;
        m0_a_channel = A_W'({$urandom(), $urandom()});
        m1_a_channel = A_W'({$urandom(), $urandom()});
        s_d_channel = D_W'({$urandom(), $urandom()});
        s_d_error = 1'($urandom());
        #1 check_all();
        pop = sdv && exp_sdr && q.size() > 0;
        if (sdv && q.size() == 0) unexp = 1;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (exp_sav && sar) begin
            q.push_back(g);
            last = g;
            held = -1;
        end else if (g == 1 ? v1 : v0) held = g;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        m0_a_valid = 1; m1_a_valid = 1; s_a_ready = 1; s_d_valid = 1;
        m0_d_ready = 1; m1_d_ready = 1; backpressureslave = 0;
        #1;
        chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
        chk("rst_a_ready", 64'({m0_a_ready, m1_a_ready}), 64'd0);
        chk("rst_s_d_ready", 64'(s_d_ready), 64'd0);
        chk("rst_d_valid", 64'({m0_d_valid, m1_d_valid}), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_unexpected", 64'(unexpected_d), 64'd0);
        q.delete(); held = -1; last = 1; unexp = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        // Round robin with the slave answering one cycle after each request.
        step(1, 1, 1, 0, 0, 1, 1);
        repeat (6) step(1, 1, 1, 0, 1, 1, 1);
        // Lock onto m0 while the slave stalls, m1 arrives meanwhile.
        do_reset();
        step(1, 0, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0, 1, 1);
        step(1, 1, 1, 0, 0, 1, 1);
        step(1, 1, 1, 0, 0, 1, 1);
        // Fill to DEPTH, then a single pop.
        do_reset();
        repeat (DEPTH) step(1, 1, 1, 0, 0, 1, 1);
        step(1, 1, 1, 0, 0, 1, 1);
        step(1, 1, 1, 0, 1, 1, 1);
        step(1, 1, 1, 0, 0, 1, 1);
        // Slave backpressure while a request is held.
        do_reset();
        step(0, 1, 0, 0, 0, 1, 1);
        repeat (5) step(1, 1, 1, 1, 0, 1, 1);
        step(1, 1, 1, 0, 0, 1, 1);
        step(1, 1, 1, 0, 0, 1, 1);
        // Head master stalls its D channel; response order must hold.
        repeat (3) step(1, 1, 1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 1);
        repeat (4) step(0, 0, 0, 0, 1, 1, 1);
        // Stray response with nothing outstanding.
        do_reset();
        step(0, 0, 0, 0, 1, 1, 1);
        repeat (3) step(0, 0, 0, 0, 0, 1, 1);
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tl_arb_2to1.md
TL_ARB_2TO1 -- requirements
Module: tl_arb_2to1

Interface
REQ-001 SHALL have parameter A_W, default 53, A-channel payload width.
REQ-002 SHALL have parameter D_W, default 43, D-channel payload width.
REQ-003 SHALL have parameter DEPTH, default 4, maximum outstanding A beats (power of 2, >=2).
REQ-004 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have m0_a_valid/m1_a_valid  input  1 each  master A request.
REQ-007 SHALL have m0_a_ready/m1_a_ready  output  1 each  master A accept.
REQ-008 SHALL have m0_a_channel/m1_a_channel  input  A_W each  master A payload, opaque.
REQ-009 SHALL have m0_d_valid/m1_d_valid  output  1 each; m0_d_ready/m1_d_ready  input  1 each.
REQ-010 SHALL have m0_d_channel/m1_d_channel  output  D_W each; m0_d_error/m1_d_error  output  1 each.
REQ-011 SHALL have s_a_valid  output  1; s_a_ready  input  1; s_a_channel  output  A_W  toward slave.
REQ-012 SHALL have s_d_valid  input  1; s_d_ready  output  1; s_d_channel  input  D_W; s_d_error  input  1.
REQ-013 SHALL have backpressureslave  input  1  slave stall; high blocks new A grants.
REQ-014 SHALL have outstanding  output  $clog2(DEPTH)+1  in-flight A beat count.
REQ-015 SHALL have unexpected_d  output  1  sticky flag: D beat received with no outstanding entry.

Function
REQ-016 SHALL arbitrate A with FSM states IDLE and LOCKED; one beat per grant.
REQ-017 IDLE: SHALL pick requester round-robin; pointer favours master not granted last; both valid after reset -> m0 first.
REQ-018 IDLE -> LOCKED when a master is picked but s_a_ready low; LOCKED holds that grant, ignores other master, until handshake.
REQ-019 LOCKED -> IDLE on s_a_valid & s_a_ready; round-robin pointer SHALL update only on handshake.
REQ-020 s_a_valid SHALL equal granted master's a_valid AND NOT full (outstanding==DEPTH) AND NOT backpressureslave; s_a_channel = granted payload, combinational.
REQ-021 Granted master's a_ready SHALL = s_a_ready AND NOT full AND NOT backpressureslave; non-granted a_ready SHALL be 0.
REQ-022 Full SHALL use registered count; same-cycle D pop does not unblock A until next cycle.
REQ-023 SHALL push granted master ID (1 bit) into DEPTH-entry in-order FIFO on each A handshake; slave returns exactly one D per A, in order.
REQ-024 SHALL steer s_d_valid, s_d_channel, s_d_error to master at FIFO head; other master's d_valid 0; d_channel/d_error zero when invalid.
REQ-025 s_d_ready SHALL equal head master's d_ready; FIFO pops on s_d_valid & s_d_ready.
REQ-026 Simultaneous push and pop SHALL leave outstanding unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-027 FIFO empty and s_d_valid high: s_d_ready SHALL be 1 (beat dropped), no master d_valid, unexpected_d set; cleared only by reset.
REQ-028 backpressureslave rising while LOCKED SHALL keep grant and FSM state; only s_a_valid and a_ready drop.
REQ-029 Combinational paths SHALL exist only valid/ready/payload steering; no loop from s_a_ready to s_a_valid.

Reset
REQ-030 reset low SHALL asynchronously force: FSM IDLE, pointer favours m0, FIFO empty, outstanding=0, unexpected_d=0; all valid/ready outputs 0 while low.
REQ-031 Reset asserted mid-transaction SHALL discard all in-flight IDs; responses after release are unexpected (REQ-027).

Verification
REQ-032 Both masters valid continuously, s_a_ready=1, slave answers 1 cycle later -> grants m0,m1,m0,m1; each D beat lands on issuing master.
REQ-033 m0 valid, s_a_ready=0 for 3 cycles, m1 raises valid meanwhile -> grant stays m0 (LOCKED); m1 granted cycle after m0 handshake.
REQ-034 Issue 4 A beats, withhold D -> outstanding=4, both a_ready 0; one D pop -> a_ready returns next cycle, outstanding 3.
REQ-035 backpressureslave=1 for 5 cycles with pending requests -> s_a_valid 0, no pushes; release -> resumes, grant unchanged.
REQ-036 m1 d_ready=0 with m1 response at head, m0 response behind -> s_d_ready 0, m0 d_valid 0 until m1 accepts (order kept).
REQ-037 s_d_valid with outstanding=0 -> beat consumed, unexpected_d=1, persists until reset low.
